// File: rtl/ramp_ref_gen_mc.sv
// Multi-mode ramp reference source with overclocked update rate.
// Emits NUM_CH lagged copies of the ramp for filter input/expected comparison.
module ramp_ref_gen_mc #(
    parameter int DATA_W    = 16,
    parameter int STEP_W    = 16,
    parameter int NUM_CH    = 2,
    parameter int OVERCLOCK = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clk_enable,
    input  logic [1:0]               mode,
    input  logic                     load,
    input  logic [DATA_W-1:0]        start_val,
    input  logic [STEP_W-1:0]        step,
    input  logic [DATA_W-1:0]        lim_lo,
    input  logic [DATA_W-1:0]        lim_hi,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic                     out_valid,
    output logic                     busy_dir
);

    // Two guard bits keep acc +/- step exact for any input combination.
    localparam int XW  = ((DATA_W > STEP_W) ? DATA_W : STEP_W) + 2;
    localparam int OCW = (OVERCLOCK > 1) ? $clog2(OVERCLOCK + 1) : 1;

    localparam logic [1:0] MODE_HOLD = 2'd0;
    localparam logic [1:0] MODE_SAW  = 2'd1;
    localparam logic [1:0] MODE_TRI  = 2'd2;
    localparam logic [1:0] MODE_SAT  = 2'd3;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    logic [OCW-1:0]           oc_cnt;
    logic [OCW-1:0]           oc_nxt;
    logic                     tick;
    logic signed [DATA_W-1:0] acc;
    logic signed [DATA_W-1:0] acc_nxt;
    logic                     dir;
    logic                     dir_nxt;
    logic                     valid_q;
    logic [DATA_W-1:0]        hist [NUM_CH];

    logic signed [XW-1:0] acc_x;
    logic signed [XW-1:0] step_x;
    logic signed [XW-1:0] lo_x;
    logic signed [XW-1:0] hi_x;
    logic signed [XW-1:0] sum_x;
    logic signed [XW-1:0] dif_x;
    logic                 cfg_ok;

    assign tick   = clk_enable && (oc_cnt == OCW'(1));
    assign oc_nxt = (oc_cnt == OCW'(OVERCLOCK)) ? OCW'(1)
                                                 : oc_cnt + OCW'(1);

    always_comb begin
        acc_x   = XW'(acc);
        step_x  = XW'(step);
        lo_x    = XW'($signed(lim_lo));
        hi_x    = XW'($signed(lim_hi));
        sum_x   = acc_x + step_x;
        dif_x   = acc_x - step_x;
        cfg_ok  = (step != '0) && (lo_x <= hi_x);
        acc_nxt = acc;
        dir_nxt = dir;
        // Zero step or inverted limits freeze both value and direction.
        if (cfg_ok) begin
            unique case (mode)
                MODE_HOLD: begin
                    acc_nxt = acc;
                end
                MODE_SAW: begin
                    if (sum_x > hi_x)
                        acc_nxt = DATA_W'(lo_x);
                    else
                        acc_nxt = DATA_W'(sum_x);
                end
                MODE_TRI: begin
                    if (dir == DIR_UP) begin
                        if (sum_x > hi_x) begin
                            acc_nxt = DATA_W'(hi_x);
                            dir_nxt = DIR_DOWN;
                        end else begin
                            acc_nxt = DATA_W'(sum_x);
                        end
                    end else begin
                        if (dif_x < lo_x) begin
                            acc_nxt = DATA_W'(lo_x);
                            dir_nxt = DIR_UP;
                        end else begin
                            acc_nxt = DATA_W'(dif_x);
                        end
                    end
                end
                MODE_SAT: begin
                    if (sum_x > hi_x)
                        acc_nxt = DATA_W'(hi_x);
                    else
                        acc_nxt = DATA_W'(sum_x);
                end
                default: acc_nxt = acc;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            oc_cnt  <= OCW'(1);
            acc     <= '0;
            dir     <= DIR_UP;
            valid_q <= 1'b0;
            for (int k = 0; k < NUM_CH; k++)
                hist[k] <= '0;
        end else if (load) begin
            oc_cnt  <= OCW'(1);
            acc     <= $signed(start_val);
            dir     <= DIR_UP;
            valid_q <= 1'b0;
        end else begin
            valid_q <= tick;
            if (clk_enable)
                oc_cnt <= oc_nxt;
            if (tick) begin
                hist[0] <= acc;
                for (int k = NUM_CH - 1; k > 0; k--)
                    hist[k] <= hist[k-1];
                acc <= acc_nxt;
                dir <= dir_nxt;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign out_data[g*DATA_W +: DATA_W] = hist[g];
    end

    assign out_valid = valid_q;
    assign busy_dir  = dir;

endmodule
